// File: rtl/vga_pkg.sv
// Shared VGA 640x480@60 timing constants and the coordinate type used by every
// pixel-position consumer.
package vga_pkg;

    localparam int VGA_H_VISIBLE = 640;
    localparam int VGA_H_FRONT   = 16;
    localparam int VGA_H_SYNC    = 96;
    localparam int VGA_H_BACK    = 48;
    localparam int VGA_V_VISIBLE = 480;
    localparam int VGA_V_FRONT   = 10;
    localparam int VGA_V_SYNC    = 2;
    localparam int VGA_V_BACK    = 33;

    localparam int VGA_H_TOTAL = VGA_H_VISIBLE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
    localparam int VGA_V_TOTAL = VGA_V_VISIBLE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

    localparam int VGA_H_SYNC_START = VGA_H_VISIBLE + VGA_H_FRONT;
    localparam int VGA_H_SYNC_END   = VGA_H_SYNC_START + VGA_H_SYNC - 1;
    localparam int VGA_V_SYNC_START = VGA_V_VISIBLE + VGA_V_FRONT;
    localparam int VGA_V_SYNC_END   = VGA_V_SYNC_START + VGA_V_SYNC - 1;

    typedef logic [9:0] coord_t;

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle: the timing generator drives it, pixel consumers read it.
interface vga_timing_gen_if;
    import vga_pkg::*;

    logic       pixel_en;
    coord_t     pixelx;
    coord_t     pixely;
    logic       video_on;
    logic       hsync;
    logic       vsync;
    logic       frame_start;
    logic [7:0] frame_count;

    modport master (
        output pixel_en, pixelx, pixely, video_on, hsync, vsync, frame_start, frame_count
    );
    modport slave (
        input  pixel_en, pixelx, pixely, video_on, hsync, vsync, frame_start, frame_count
    );

endinterface

// File: rtl/pixel_tick.sv
// Divides the system clock down to a one-clock pixel-rate strobe.
module pixel_tick #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    output logic pixel_en
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] div_cnt_q, div_cnt_d;

    // Gated by rst so a CLK_DIV=1 build does not strobe while held in reset.
    always_comb begin
        pixel_en  = !rst && (div_cnt_q == LAST);
        div_cnt_d = (div_cnt_q == LAST) ? '0 : div_cnt_q + DW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) div_cnt_q <= '0;
        else     div_cnt_q <= div_cnt_d;
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel-rate divider, h/v counters, registered sync and
// visible-area decodes, frame bookkeeping.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int CLK_DIV   = 2,
    parameter int H_VISIBLE = VGA_H_VISIBLE,
    parameter int H_FRONT   = VGA_H_FRONT,
    parameter int H_SYNC    = VGA_H_SYNC,
    parameter int H_BACK    = VGA_H_BACK,
    parameter int V_VISIBLE = VGA_V_VISIBLE,
    parameter int V_FRONT   = VGA_V_FRONT,
    parameter int V_SYNC    = VGA_V_SYNC,
    parameter int V_BACK    = VGA_V_BACK
) (
    input  logic             clk,
    input  logic             rst,
    vga_timing_gen_if.master vga
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam coord_t H_LAST     = coord_t'(H_TOTAL - 1);
    localparam coord_t V_LAST     = coord_t'(V_TOTAL - 1);
    localparam coord_t H_VIS      = coord_t'(H_VISIBLE);
    localparam coord_t V_VIS      = coord_t'(V_VISIBLE);
    localparam coord_t HS_START   = coord_t'(H_VISIBLE + H_FRONT);
    localparam coord_t HS_END     = coord_t'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam coord_t VS_START   = coord_t'(V_VISIBLE + V_FRONT);
    localparam coord_t VS_END     = coord_t'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    logic       pixel_en;
    coord_t     hcount_q, hcount_d;
    coord_t     vcount_q, vcount_d;
    logic [7:0] frame_count_q, frame_count_d;
    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;
    logic       video_on_q, video_on_d;

    pixel_tick #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk      (clk),
        .rst      (rst),
        .pixel_en (pixel_en)
    );

    always_comb begin
        hcount_d      = hcount_q;
        vcount_d      = vcount_q;
        frame_count_d = frame_count_q;
        if (pixel_en) begin
            if (hcount_q == H_LAST) begin
                hcount_d = '0;
                if (vcount_q == V_LAST) begin
                    vcount_d      = '0;
                    frame_count_d = frame_count_q + 8'd1;
                end else begin
                    vcount_d = vcount_q + coord_t'(1);
                end
            end else begin
                hcount_d = hcount_q + coord_t'(1);
            end
        end
        // Decoded from next-state counts so the registered flags line up with pixelx/pixely.
        hsync_d    = !((hcount_d >= HS_START) && (hcount_d <= HS_END));
        vsync_d    = !((vcount_d >= VS_START) && (vcount_d <= VS_END));
        video_on_d = (hcount_d < H_VIS) && (vcount_d < V_VIS);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hcount_q      <= '0;
            vcount_q      <= '0;
            frame_count_q <= '0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            video_on_q    <= 1'b1;
        end else begin
            hcount_q      <= hcount_d;
            vcount_q      <= vcount_d;
            frame_count_q <= frame_count_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            video_on_q    <= video_on_d;
        end
    end

    assign vga.pixel_en    = pixel_en;
    assign vga.pixelx      = hcount_q;
    assign vga.pixely      = vcount_q;
    assign vga.video_on    = video_on_q;
    assign vga.hsync       = hsync_q;
    assign vga.vsync       = vsync_q;
    assign vga.frame_count = frame_count_q;
    assign vga.frame_start = pixel_en && (hcount_q == '0) && (vcount_q == '0);

endmodule

// File: tb/tb_vga_timing_gen.sv
// Three builds (default 640x480 /2, small raster /2, small raster /1) scored
// every clock against a closed-form raster model, plus window/period checks.
module tb_vga_timing_gen;
    import vga_pkg::*;

    logic clk   = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;
    always #5 clk = ~clk;

    vga_timing_gen_if vif_a ();
    vga_timing_gen_if vif_b ();
    vga_timing_gen_if vif_c ();

    vga_timing_gen #(.CLK_DIV(2)) dut_a (.clk(clk), .rst(rst_a), .vga(vif_a));

    vga_timing_gen #(
        .CLK_DIV(2), .H_VISIBLE(16), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)
    ) dut_b (.clk(clk), .rst(rst_b), .vga(vif_b));

    vga_timing_gen #(
        .CLK_DIV(1), .H_VISIBLE(16), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)
    ) dut_c (.clk(clk), .rst(rst_a), .vga(vif_c));

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // {pixel_en, frame_start, video_on, hsync, vsync, frame_count, pixely, pixelx}
    function automatic logic [32:0] model(input longint t, input logic r, input int cd,
                                          input int ht, input int vt, input int hv,
                                          input int hss, input int hse, input int vv,
                                          input int vss, input int vse);
        longint p, x, y, f;
        logic pe, fs, von, hs, vs;
        p   = t / cd;
        x   = p % ht;
        y   = (p / ht) % vt;
        f   = (p / (ht * vt)) % 256;
        pe  = !r && ((t % cd) == cd - 1);
        fs  = pe && x == 0 && y == 0;
        von = (x < hv) && (y < vv);
        hs  = !(x >= hss && x <= hse);
        vs  = !(y >= vss && y <= vse);
        return {pe, fs, von, hs, vs, f[7:0], y[9:0], x[9:0]};
    endfunction

    function automatic logic [32:0] snap(input int id);
        case (id)
            0: return {vif_a.pixel_en, vif_a.frame_start, vif_a.video_on, vif_a.hsync,
                       vif_a.vsync, vif_a.frame_count, vif_a.pixely, vif_a.pixelx};
            1: return {vif_b.pixel_en, vif_b.frame_start, vif_b.video_on, vif_b.hsync,
                       vif_b.vsync, vif_b.frame_count, vif_b.pixely, vif_b.pixelx};
            default: return {vif_c.pixel_en, vif_c.frame_start, vif_c.video_on, vif_c.hsync,
                             vif_c.vsync, vif_c.frame_count, vif_c.pixely, vif_c.pixelx};
        endcase
    endfunction

    typedef struct {
        int          id;
        logic [32:0] exp;
    } sb_t;
    sb_t sb_q[$];

    longint ta = 0, tb = 0;
    bit     va = 0, vb = 0;

    // Expected state after each edge is queued at the edge, then scored 1 time unit later.
    always @(posedge clk) begin
        logic ra, rb;
        ra = rst_a;
        rb = rst_b;
        ta = ra ? 0 : ta + 1;
        tb = rb ? 0 : tb + 1;
        if (ra) va = 1;
        if (rb) vb = 1;
        if (va) begin
            sb_q.push_back('{0, model(ta, ra, 2, 800, 525, 640, 656, 751, 480, 490, 491)});
            sb_q.push_back('{2, model(ta, ra, 1, 24, 10, 16, 18, 20, 6, 7, 8)});
        end
        if (vb)
            sb_q.push_back('{1, model(tb, rb, 2, 24, 10, 16, 18, 20, 6, 7, 8)});
        #1;
        while (sb_q.size() > 0) begin
            sb_t e;
            e = sb_q.pop_front();
            case (e.id)
                0:       check("raster_a", 64'(snap(0)), 64'(e.exp));
                1:       check("raster_b", 64'(snap(1)), 64'(e.exp));
                default: check("raster_c", 64'(snap(2)), 64'(e.exp));
            endcase
        end
    end

    // Sync/blanking windows and frame periods measured directly from the outputs.
    int   cyc = 0;
    int   a_hs_run = 0, b_vs_run = 0;
    logic a_hs_prev = 1'b1, a_von_prev = 1'b1, b_vs_prev = 1'b1;
    int   b_last = -1, c_last = -1, b_frames = 0;

    always @(posedge clk) begin
        #1;
        cyc++;
        if (!rst_a) begin
            if (a_hs_prev && !vif_a.hsync) check("a_hs_fall_x", 64'(vif_a.pixelx), 64'd656);
            if (!a_hs_prev && vif_a.hsync) begin
                check("a_hs_rise_x", 64'(vif_a.pixelx), 64'd752);
                check("a_hs_width", 64'(a_hs_run), 64'd192);
            end
            if (a_von_prev && !vif_a.video_on) check("a_von_fall_x", 64'(vif_a.pixelx), 64'd640);
            if (vif_c.frame_start) begin
                if (c_last >= 0) check("c_frame_len", 64'(cyc - c_last), 64'd240);
                c_last = cyc;
            end
        end
        a_hs_run   = vif_a.hsync ? 0 : a_hs_run + 1;
        a_hs_prev  = vif_a.hsync;
        a_von_prev = vif_a.video_on;

        if (rst_b) begin
            b_last   = -1;
            b_frames = 0;
            b_vs_run = 0;
        end else begin
            if (!b_vs_prev && vif_b.vsync) check("b_vs_width", 64'(b_vs_run), 64'd96);
            if (vif_b.frame_start) begin
                if (b_last >= 0) check("b_frame_len", 64'(cyc - b_last), 64'd480);
                check("b_frame_cnt", 64'(vif_b.frame_count), 64'(b_frames));
                b_last = cyc;
                b_frames++;
            end
            b_vs_run = vif_b.vsync ? 0 : b_vs_run + 1;
        end
        b_vs_prev = vif_b.vsync;
    end

    initial begin
        bit hit;
        repeat (3) @(negedge clk);
        rst_a = 1'b0;
        rst_b = 1'b0;
        // Pull the small raster back to (0,0) from mid-frame for one cycle.
        hit = 0;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (vif_b.pixelx == 10'd10 && vif_b.pixely == 10'd4) begin
                hit = 1;
                break;
            end
        end
        check("b_mid_reached", 64'(hit), 64'd1);
        rst_b = 1'b1;
        @(negedge clk);
        rst_b = 1'b0;
        repeat (5200) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Raster timing generator for the 640x480@60 Hz VGA output. It divides the system clock into a pixel-rate enable and runs the horizontal and vertical counters. It drives hsync/vsync to the connector and exports the current raster position (pixelx, pixely). This block sits directly upstream of the sprite address generator and board renderer: every pixel-position consumer takes pixelx/pixely, video_on and pixel_en from here.

## Interface
Parameters:
- CLK_DIV, 2: system clocks per pixel (50 MHz to 25 MHz); legal values ≥1.
- H_VISIBLE, 640: visible pixels per line.
- H_FRONT, 16: horizontal front porch, in pixels.
- H_SYNC, 96: hsync pulse width, in pixels.
- H_BACK, 48: horizontal back porch, in pixels.
- V_VISIBLE, 480: visible lines per frame.
- V_FRONT, 10: vertical front porch, in lines.
- V_SYNC, 2: vsync pulse width, in lines.
- V_BACK, 33: vertical back porch, in lines.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- pixel_en  out  1  one-clk strobe; the raster advances at the clock edge after the strobe.
- pixelx  out  10  current horizontal count, 0..H_TOTAL-1.
- pixely  out  10  current vertical count, 0..V_TOTAL-1.
- video_on  out  1  high when the current position is visible.
- hsync  out  1  active-low horizontal sync.
- vsync  out  1  active-low vertical sync.
- frame_start  out  1  one-clk pulse at the first pixel_en of pixel (0,0).
- frame_count  out  8  number of completed frames, wraps modulo 256.

## Operation
- Derived values: H_TOTAL = H_VISIBLE+H_FRONT+H_SYNC+H_BACK (800); V_TOTAL = V_VISIBLE+V_FRONT+V_SYNC+V_BACK (525). Both totals must be ≤1024 so they fit the 10-bit outputs.
- Divider div_cnt runs 0..CLK_DIV-1 and wraps. pixel_en = (div_cnt == CLK_DIV-1), decoded combinationally. With CLK_DIV=1, pixel_en is constantly 1 outside reset.
- On a clock edge with pixel_en=1, the horizontal and vertical counters advance:
  - hcount increments. At H_TOTAL-1 it wraps to 0 and vcount increments.
  - When vcount is at V_TOTAL-1 and hcount wraps, vcount also wraps to 0 and frame_count increments.
- pixelx = hcount and pixely = vcount, driven straight from the counter registers.
- hsync, vsync and video_on are registers. Each is loaded from the next-state counter values, so it always describes the pixelx/pixely shown on the same cycle.
  - hsync = 0 iff pixelx ∈ [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1], i.e. [656, 751].
  - vsync = 0 iff pixely ∈ [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC-1], i.e. [490, 491].
  - video_on = (pixelx < H_VISIBLE) && (pixely < V_VISIBLE).
- frame_start = pixel_en && pixelx==0 && pixely==0, decoded combinationally.
- State: no FSM beyond the three counters. The porch and sync regions are pure decodes of the counters.

## Timing
- Reset values: div_cnt=0, pixelx=0, pixely=0, frame_count=0, hsync=1, vsync=1, video_on=1. pixel_en and frame_start are 0 when CLK_DIV>1.
- Reset has priority over counting. An assertion in mid-frame returns the raster to (0,0) at the next edge, with no partial-frame count.
- First pixel_en after reset release: on cycle CLK_DIV-1, counting the first cycle with rst low as cycle 0. frame_start pulses on that same cycle.
- Each (pixelx, pixely) value is held for exactly CLK_DIV clocks.
- Counts per frame:
  - One line = H_TOTAL·CLK_DIV clocks (1600).
  - One frame = H_TOTAL·V_TOTAL·CLK_DIV clocks (840 000).
  - frame_start pulses exactly once per frame.
- Downstream latency contract: consumers register their pixel result on the pixel_en edge. They get one pixel period of pipeline, and the colour they produce is delayed one pixel relative to hsync. This is accepted and matches the sprite path.
- Wrap corner: at (799, 524) with pixel_en=1, the next edge yields (0,0), video_on=1, vsync=1, hsync=1, and frame_count+1. All of these change on that single edge.

## Structure
- Shared package vga_pkg holds:
  - The eight porch and visible constants.
  - H_TOTAL and V_TOTAL.
  - The sync-start and sync-end localparams.
  - The 10-bit coordinate typedef coord_t, used by pixelx, pixely and the downstream posx/posy.
- One sub-module, pixel_tick. It contains the CLK_DIV divider with the clk, rst and pixel_en interface. It is reused by any other block needing the pixel rate.
- Horizontal and vertical counters live in the top module.

## Test plan
- Reset release with CLK_DIV=2: pixel_en first high on cycle 1, with frame_start=1 on that same cycle. pixelx reads 0, 0, 1, 1, 2… on successive clocks.
- Line wrap: run to pixelx=799, pixely=0. The next pixel_en edge gives pixelx=0, pixely=1, hsync=1 and video_on=1.
- Horizontal sync window: hsync goes low exactly at pixelx=656 and returns high at 752. It stays low for 96·2=192 clocks. video_on falls at pixelx=640.
- Vertical sync window and frame wrap:
  - vsync is low only for pixely 490–491, lasting 3200 clocks.
  - video_on stays 0 for every pixely ≥480.
  - After (799, 524) the raster returns to (0,0) and frame_count goes from 0 to 1.
- Reset mid-frame: assert rst at pixel (300, 200) for one cycle. The next edge shows (0,0), frame_count unchanged, hsync=vsync=1. Check one full frame afterwards: it is 840 000 clocks between frame_start pulses.
- CLK_DIV=1 build: pixel_en is constant 1, pixelx increments every clock, and a frame is 420 000 clocks long.
